// File: rtl/adder_accum.sv
// adder_accum
//   Accumulates NUM_SAMPLES consecutive 5-bit results ({carry, sum}) from an
//   upstream 4-bit adder into an 8-bit modulo-256 total. When the batch is
//   complete, the result is held for a valid/ready handshake.
//
// Parameters
//   NUM_SAMPLES  samples summed per output batch (1..15)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream adder result present
//   in_ready   block accepts a result this cycle (high in ACC)
//   in_sum     4-bit adder sum
//   in_cout    adder carry out
//   clear      synchronous flush, highest priority
//   out_valid  accumulated result available (high in HOLD)
//   out_ready  downstream accepts the result
//   out_total  accumulated total modulo 256
//   out_count  samples accepted in the current batch
//   out_ovf    sticky: true total exceeded 255
module adder_accum #(
    parameter int unsigned NUM_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_sum,
    input  logic       in_cout,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_total,
    output logic [3:0] out_count,
    output logic       out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(NUM_SAMPLES);

    state_t     r_state;
    logic [7:0] r_total;
    logic [3:0] r_count;
    logic       r_ovf;

    logic [8:0] w_sum_ext;
    logic [3:0] w_count_next;

    // Ninth bit of the widened add is the carry out of the 8-bit total.
    assign w_sum_ext    = {1'b0, r_total} + {4'b0000, in_cout, in_sum};
    assign w_count_next = r_count + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_total <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            // Flush wins over any accept or handshake on this edge.
            r_state <= ACC;
            r_total <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (in_valid) begin
                        r_total <= w_sum_ext[7:0];
                        r_ovf   <= r_ovf | w_sum_ext[8];
                        r_count <= w_count_next;
                        if (w_count_next == LAST_COUNT) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= ACC;
                        r_total <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    // Handshake flags decode from state alone.
    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == HOLD);
    assign out_total = r_total;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_accum.sv
module tb_adder_accum;

    typedef struct packed {
        logic [7:0] total;
        logic [3:0] count;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    // DUT A: default NUM_SAMPLES=4
    logic       a_rst_n, a_in_valid, a_in_ready, a_in_cout, a_clear;
    logic       a_out_valid, a_out_ready, a_out_ovf;
    logic [3:0] a_in_sum, a_out_count;
    logic [7:0] a_out_total;

    // DUT B: NUM_SAMPLES=15
    logic       b_rst_n, b_in_valid, b_in_ready, b_in_cout, b_clear;
    logic       b_out_valid, b_out_ready, b_out_ovf;
    logic [3:0] b_in_sum, b_out_count;
    logic [7:0] b_out_total;

    adder_accum dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sum(a_in_sum), .in_cout(a_in_cout), .clear(a_clear),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_total(a_out_total), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    adder_accum #(.NUM_SAMPLES(15)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sum(b_in_sum), .in_cout(b_in_cout), .clear(b_clear),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_total(b_out_total), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare presented result against queue front; pop on handshake or flush.
    always @(negedge clk) begin
        if (a_rst_n === 1'b1 && a_out_valid === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_result: got total=%0h count=%0d ovf=%0b with nothing expected",
                         a_out_total, a_out_count, a_out_ovf);
            end else begin
                if ({a_out_total, a_out_count, a_out_ovf} !== qa[0]) begin
                    errors++;
                    $display("FAIL a_result: got total=%0h count=%0d ovf=%0b expected total=%0h count=%0d ovf=%0b",
                             a_out_total, a_out_count, a_out_ovf, qa[0].total, qa[0].count, qa[0].ovf);
                end
                if (a_out_ready === 1'b1 || a_clear === 1'b1) void'(qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (b_rst_n === 1'b1 && b_out_valid === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_result: got total=%0h count=%0d ovf=%0b with nothing expected",
                         b_out_total, b_out_count, b_out_ovf);
            end else begin
                if ({b_out_total, b_out_count, b_out_ovf} !== qb[0]) begin
                    errors++;
                    $display("FAIL b_result: got total=%0h count=%0d ovf=%0b expected total=%0h count=%0d ovf=%0b",
                             b_out_total, b_out_count, b_out_ovf, qb[0].total, qb[0].count, qb[0].ovf);
                end
                if (b_out_ready === 1'b1 || b_clear === 1'b1) void'(qb.pop_front());
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic c, input logic [3:0] s);
        a_in_valid = 1'b1;
        a_in_cout  = c;
        a_in_sum   = s;
        step();
    endtask

    task automatic a_idle(input int unsigned n);
        a_in_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic a_basic_batch;
        a_send(1'b0, 4'h0);
        a_send(1'b0, 4'h8);
        a_send(1'b1, 4'h0);
        a_send(1'b0, 4'hF);
        a_in_valid = 1'b0;
    endtask

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_cout = 1'b0; a_in_sum = '0;
        a_clear = 1'b0; a_out_ready = 1'b1;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_cout = 1'b0; b_in_sum = '0;
        b_clear = 1'b0; b_out_ready = 1'b1;

        // Reset state
        #2;
        chk("reset_total", 32'(a_out_total), 32'h00);
        chk("reset_count", 32'(a_out_count), 32'd0);
        chk("reset_ovf", 32'(a_out_ovf), 32'd0);
        chk("reset_out_valid", 32'(a_out_valid), 32'd0);
        chk("reset_in_ready", 32'(a_in_ready), 32'd1);
        step(); step();
        #2 a_rst_n = 1'b1; b_rst_n = 1'b1;
        step();

        // Basic batch: 0+8+16+15 = 39
        qa.push_back('{total: 8'h27, count: 4'd4, ovf: 1'b0});
        a_basic_batch();
        chk("basic_out_valid", 32'(a_out_valid), 32'd1);
        chk("basic_in_ready_hold", 32'(a_in_ready), 32'd0);
        step();
        chk("basic_after_in_ready", 32'(a_in_ready), 32'd1);
        chk("basic_after_count", 32'(a_out_count), 32'd0);
        chk("basic_after_total", 32'(a_out_total), 32'd0);

        // Gapped input: same total
        qa.push_back('{total: 8'h27, count: 4'd4, ovf: 1'b0});
        a_send(1'b0, 4'h0); a_in_sum = 4'h7; a_in_cout = 1'b1; a_idle(1);
        a_send(1'b0, 4'h8); a_in_sum = 4'h7; a_idle(1);
        chk("gap_count_mid", 32'(a_out_count), 32'd2);
        a_send(1'b1, 4'h0); a_in_sum = 4'h7; a_idle(1);
        a_send(1'b0, 4'hF);
        a_idle(2);

        // Backpressure: 31+31+1+2 = 65
        a_out_ready = 1'b0;
        qa.push_back('{total: 8'h41, count: 4'd4, ovf: 1'b0});
        a_send(1'b1, 4'hF);
        a_send(1'b1, 4'hF);
        a_send(1'b0, 4'h1);
        a_send(1'b0, 4'h2);
        for (int unsigned i = 0; i < 5; i++) begin
            a_in_valid = (i % 2 == 0);
            a_in_cout  = 1'b1;
            a_in_sum   = 4'hF;
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            chk("bp_total", 32'(a_out_total), 32'h41);
            step();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step();
        chk("bp_release_total", 32'(a_out_total), 32'd0);
        chk("bp_release_count", 32'(a_out_count), 32'd0);
        chk("bp_release_in_ready", 32'(a_in_ready), 32'd1);

        // Clear after two accepts, coinciding with a third offered sample
        a_send(1'b0, 4'h5);
        a_send(1'b0, 4'h6);
        a_clear = 1'b1; a_in_valid = 1'b1; a_in_sum = 4'h9;
        step();
        a_clear = 1'b0; a_in_valid = 1'b0;
        chk("clear_total", 32'(a_out_total), 32'd0);
        chk("clear_count", 32'(a_out_count), 32'd0);
        chk("clear_in_ready", 32'(a_in_ready), 32'd1);

        // Clear in HOLD discards the result: 1+2+3+4 = 10
        a_out_ready = 1'b0;
        qa.push_back('{total: 8'h0A, count: 4'd4, ovf: 1'b0});
        a_send(1'b0, 4'h1);
        a_send(1'b0, 4'h2);
        a_send(1'b0, 4'h3);
        a_send(1'b0, 4'h4);
        a_in_valid = 1'b0;
        step();
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        chk("clear_hold_out_valid", 32'(a_out_valid), 32'd0);
        chk("clear_hold_total", 32'(a_out_total), 32'd0);
        chk("clear_hold_count", 32'(a_out_count), 32'd0);
        a_out_ready = 1'b1;
        a_idle(2);

        // Async reset mid-batch, between edges
        a_send(1'b1, 4'h3);
        a_send(1'b0, 4'h4);
        a_in_valid = 1'b0;
        #2 a_rst_n = 1'b0;
        #1;
        chk("areset_total", 32'(a_out_total), 32'd0);
        chk("areset_count", 32'(a_out_count), 32'd0);
        chk("areset_in_ready", 32'(a_in_ready), 32'd1);
        a_rst_n = 1'b1;
        step();
        qa.push_back('{total: 8'h27, count: 4'd4, ovf: 1'b0});
        a_basic_batch();
        a_idle(2);

        // Overflow with NUM_SAMPLES=15: 15 * 30 = 450 -> 0xC2, ovf set
        qb.push_back('{total: 8'hC2, count: 4'd15, ovf: 1'b1});
        for (int unsigned i = 0; i < 15; i++) begin
            b_in_valid = 1'b1; b_in_cout = 1'b1; b_in_sum = 4'hE;
            if (i == 14) chk("b_count_before_last", 32'(b_out_count), 32'd14);
            step();
        end
        b_in_valid = 1'b0;
        chk("b_out_valid", 32'(b_out_valid), 32'd1);
        step();
        chk("b_after_ovf", 32'(b_out_ovf), 32'd0);

        // Bounded drain of any outstanding expectations
        for (int unsigned i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) step();
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
